// File: rtl/instruction_sequencer_pkg.sv
// Shared widths, opcode/func encodings and FSM states for the instruction sequencer.
package instruction_sequencer_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REGS  = 4;
    localparam int REG_AW    = $clog2(NUM_REGS);

    localparam logic [3:0] OPCODE_RTYPE = 4'd15;
    localparam logic [3:0] OPCODE_ADI   = 4'd4;
    localparam logic [3:0] OPCODE_LHI   = 4'd6;
    localparam logic [3:0] OPCODE_JMP   = 4'd9;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_WWD = 6'd28;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_e;

    function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
        return {{(WORD_SIZE-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/instruction_sequencer_register_file.sv
// Architectural register file: two combinational read ports, one synchronous write port.
module register_file
    import instruction_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_AW-1:0]    raddr1_i,
    input  logic [REG_AW-1:0]    raddr2_i,
    input  logic                 we_i,
    input  logic [REG_AW-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    output logic [WORD_SIZE-1:0] rdata1_o,
    output logic [WORD_SIZE-1:0] rdata2_o
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/instruction_sequencer.sv
// Two-state fetch/execute controller that drives an external combinational ALU.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_opcode,
    output logic [5:0]           alu_func,
    input  logic [WORD_SIZE-1:0] alu_c,
    output logic [WORD_SIZE-1:0] output_port,
    output logic [WORD_SIZE-1:0] num_inst
);

    state_e               state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] ir_q;
    logic [WORD_SIZE-1:0] out_q;
    logic [WORD_SIZE-1:0] cnt_q;

    logic [3:0]           op;
    logic [REG_AW-1:0]    rs, rt, rd;
    logic [5:0]           func;
    logic [7:0]           imm;
    logic [11:0]          target;
    logic [WORD_SIZE-1:0] rs_data, rt_data;
    logic                 rf_we;
    logic [REG_AW-1:0]    rf_waddr;
    logic                 exec;

    assign op     = ir_q[15:12];
    assign rs     = ir_q[11:10];
    assign rt     = ir_q[9:8];
    assign rd     = ir_q[7:6];
    assign func   = ir_q[5:0];
    assign imm    = ir_q[7:0];
    assign target = ir_q[11:0];
    assign exec   = (state_q == S_EXEC);

    register_file u_rf (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (alu_c),
        .rdata1_o (rs_data),
        .rdata2_o (rt_data)
    );

    // Operand mux and writeback decode; the write lands at the end of EXEC.
    always_comb begin
        alu_b    = rt_data;
        rf_we    = 1'b0;
        rf_waddr = rt;
        case (op)
            OPCODE_RTYPE: begin
                if (func == FUNC_ADD) begin
                    rf_we    = exec;
                    rf_waddr = rd;
                end
            end
            OPCODE_ADI: begin
                alu_b = sext8(imm);
                rf_we = exec;
            end
            OPCODE_LHI: begin
                alu_b = {8'h00, imm};
                rf_we = exec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (inputReady) begin
                        ir_q    <= data;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    cnt_q   <= cnt_q + 16'd1;
                    if (op == OPCODE_JMP) begin
                        pc_q <= {pc_q[15:12], target};
                    end else begin
                        pc_q <= pc_q + 16'd1;
                    end
                    if (op == OPCODE_RTYPE && func == FUNC_WWD) begin
                        out_q <= rs_data;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Request is withheld while reset is asserted so the reset cycle never fetches.
    assign readM       = (state_q == S_FETCH) && !reset;
    assign address     = pc_q;
    assign alu_a       = rs_data;
    assign alu_opcode  = op;
    assign alu_func    = func;
    assign output_port = out_q;
    assign num_inst    = cnt_q;

endmodule
